// File: rtl/sramx_arb_pkg.sv
// Shared types for the SRAMx arbiter: SRAMx request/response structs (as in sramx.svh),
// ID/count types and defaults. Build option: SRAMX_ARB_RR_EN selects round-robin arbitration.
package sramx_arb_pkg;

    localparam int DEFAULT_NUM_REQ         = 2;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramx_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
    } sramx_resp_t;

    typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0]           arb_id_t;
    typedef logic [$clog2(DEFAULT_MAX_OUTSTANDING+1)-1:0] cnt_t;

    // Pointer/index width that stays legal when the range collapses to a single entry.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sramx_id_fifo.sv
// In-order FIFO of granted master IDs; head names the owner of the next data beat.
module sramx_id_fifo
    import sramx_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
    parameter int W     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_id,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt,
    output logic                       o_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = clog2_min1(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is the registered count, so a same-cycle pop never frees room for a push.
    assign o_full = (r_cnt == CW'(DEPTH));
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && (r_cnt != '0);
    assign o_head = r_mem[r_rd_ptr];
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sramx_arbiter.sv
// Shares one SRAMx slave among NUM_REQ masters: grant/lock FSM plus in-order data_ok steering.
// Build option: define SRAMX_ARB_RR_EN for round-robin, otherwise fixed priority (lowest index).
module sramx_arbiter
    import sramx_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEFAULT_NUM_REQ,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      reset,
    input  sramx_req_t  [NUM_REQ-1:0] m_req,
    output sramx_resp_t [NUM_REQ-1:0] m_resp,
    output sramx_req_t                s_req,
    input  sramx_resp_t               s_resp
);

    localparam int IDW = clog2_min1(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } lock_st_t;

    lock_st_t       r_state;
    logic [IDW-1:0] r_lock_id;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_head;
    logic [CW-1:0]  w_cnt;
    logic           w_full;
    logic           w_s_vld;
    logic           w_addr_hs;
    logic           w_data_hs;

`ifdef SRAMX_ARB_RR_EN
    logic [IDW-1:0] r_rr_ptr;

    always_comb begin
        logic found;
        found    = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && m_req[(32'(r_rr_ptr) + k) % NUM_REQ].req) begin
                w_winner = IDW'((32'(r_rr_ptr) + k) % NUM_REQ);
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic found;
        found    = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && m_req[k].req) begin
                w_winner = IDW'(k);
                found    = 1'b1;
            end
        end
    end
`endif

    assign w_grant   = (r_state == ST_LOCKED) ? r_lock_id : w_winner;
    assign w_s_vld   = !reset && m_req[w_grant].req && !w_full;
    assign w_addr_hs = w_s_vld && s_resp.addr_ok;
    assign w_data_hs = !reset && s_resp.data_ok && (w_cnt != '0);
    assign s_req     = w_s_vld ? m_req[w_grant] : '0;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            m_resp[i].addr_ok = w_addr_hs && (w_grant == IDW'(i));
            m_resp[i].data_ok = w_data_hs && (w_head == IDW'(i));
            m_resp[i].rdata   = s_resp.rdata;
        end
    end

    sramx_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDW)
    ) u_id_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_addr_hs),
        .i_id   (w_grant),
        .i_pop  (w_data_hs),
        .o_head (w_head),
        .o_cnt  (w_cnt),
        .o_full (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FREE;
            r_lock_id <= '0;
        end else begin
            case (r_state)
                ST_FREE: begin
                    if (w_s_vld && !s_resp.addr_ok) begin
                        r_state   <= ST_LOCKED;
                        r_lock_id <= w_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_addr_hs || !m_req[r_lock_id].req) begin
                        r_state <= ST_FREE;
                    end
                end
                default: r_state <= ST_FREE;
            endcase
        end
    end

`ifdef SRAMX_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_addr_hs) begin
            r_rr_ptr <= (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
        end
    end
`endif

    // Protocol checks: no data beat without an outstanding request; locked master must hold req.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(s_resp.data_ok && (w_cnt == '0)));
            assert (!((r_state == ST_LOCKED) && !m_req[r_lock_id].req));
        end
    end

endmodule

// File: tb/tb_sramx_arbiter.sv
// Table-driven bench for sramx_arbiter with an ID-order scoreboard on data_ok.
module tb_sramx_arbiter;
    import sramx_arb_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    sramx_req_t  [1:0]     m_req;
    sramx_resp_t [1:0]     m_resp;
    sramx_req_t            s_req;
    sramx_resp_t           s_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    localparam sramx_req_t M0 = '{req: 1'b1, wr: 1'b1, size: 2'd2, addr: 32'h0000_0A00, wdata: 32'hA0A0_A0A0};
    localparam sramx_req_t M1 = '{req: 1'b1, wr: 1'b0, size: 2'd2, addr: 32'h0000_1000, wdata: 32'h0000_0000};

    typedef struct {
        logic        rst, r0, r1, aok, dok;
        logic [31:0] rdata;
        logic        sreq, sel;
        logic [3:0]  ok;   // {addr_ok0, addr_ok1, data_ok0, data_ok1}
    } vec_t;

    vec_t vecs[$];

    sramx_arbiter #(
        .NUM_REQ         (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic add(input logic rst, r0, r1, aok, dok, input logic [31:0] rd,
                       input logic sreq, sel, input logic [3:0] ok);
        vecs.push_back('{rst, r0, r1, aok, dok, rd, sreq, sel, ok});
    endtask

    task automatic step(input logic rst, r0, r1, aok, dok, input logic [31:0] rd);
        @(posedge clk);
        #1;
        reset          = rst;
        m_req[0]       = M0;
        m_req[0].req   = r0;
        m_req[1]       = M1;
        m_req[1].req   = r1;
        s_resp.addr_ok = aok;
        s_resp.data_ok = dok;
        s_resp.rdata   = rd;
        #3;
    endtask

    task automatic check(input string nm, input int idx, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic mon(input logic rst, input int idx);
        if (rst) begin
            sb.delete();
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (m_resp[j].data_ok) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow[%0d]: got data_ok on master %0d expected none", idx, j);
                    end else begin
                        check("sb_order", idx, 80'(j), 80'(sb.pop_front()));
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (m_resp[i].addr_ok) sb.push_back(i);
            end
        end
    endtask

    function automatic sramx_req_t exp_sreq(input logic vld, input logic sel);
        if (!vld) return '0;
        return sel ? M1 : M0;
    endfunction

    initial begin
        logic [3:0] act_ok;
        int         seen;
        reset  = 1'b1;
        m_req  = '0;
        s_resp = '0;

        // rst r0 r1 aok dok rdata          sreq sel ok
        add(1, 1, 1, 1, 1, 32'h5555_5555, 0, 0, 4'b0000);
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000);
        // single read from master 1, data 3 cycles later
        add(0, 0, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 4'b0000);
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 4'b0001);
        // both masters request every cycle
`ifdef SRAMX_ARB_RR_EN
        add(0, 1, 1, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 1, 1, 1, 1, 32'h11,        1, 1, 4'b0110);
        add(0, 1, 1, 1, 1, 32'h22,        1, 0, 4'b1001);
        add(0, 1, 1, 1, 1, 32'h33,        1, 1, 4'b0110);
        add(0, 0, 0, 0, 1, 32'h44,        0, 0, 4'b0001);
`else
        add(0, 1, 1, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 1, 1, 1, 1, 32'h11,        1, 0, 4'b1010);
        add(0, 1, 1, 1, 1, 32'h22,        1, 0, 4'b1010);
        add(0, 1, 1, 1, 1, 32'h33,        1, 0, 4'b1010);
        add(0, 0, 0, 0, 1, 32'h44,        0, 0, 4'b0010);
`endif
        // master 1 locked while slave stalls, master 0 waits
        add(0, 0, 1, 0, 0, 32'h0,         1, 1, 4'b0000);
        for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 0, 32'h0, 1, 1, 4'b0000);
        add(0, 1, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 1, 0, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 0, 0, 0, 1, 32'h66,        0, 0, 4'b0001);
        add(0, 0, 0, 0, 1, 32'h77,        0, 0, 4'b0010);
        // fill to 4 outstanding, blocked 5th, pop-only while full, push+pop, refill
        add(0, 1, 0, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 0, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 1, 0, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 0, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 1, 0, 1, 0, 32'h0,         0, 0, 4'b0000);
        add(0, 1, 0, 1, 1, 32'h88,        0, 0, 4'b0010);
        add(0, 1, 0, 1, 1, 32'h99,        1, 0, 4'b1001);
        add(0, 0, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 1, 0, 1, 0, 32'h0,         0, 0, 4'b0000);
        add(0, 0, 0, 0, 1, 32'hAA,        0, 0, 4'b0010);
        // lock on master 0 with 3 outstanding, then reset with a stray data_ok
        add(0, 1, 0, 0, 0, 32'h0,         1, 0, 4'b0000);
        add(1, 1, 0, 0, 1, 32'hBB,        0, 0, 4'b0000);
        add(0, 0, 1, 0, 0, 32'h0,         1, 1, 4'b0000);
        add(0, 0, 1, 1, 0, 32'h0,         1, 1, 4'b0100);
        add(0, 1, 0, 1, 0, 32'h0,         1, 0, 4'b1000);
        add(0, 0, 0, 0, 1, 32'hCC,        0, 0, 4'b0001);
        add(0, 0, 0, 0, 1, 32'hDD,        0, 0, 4'b0010);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].r0, vecs[n].r1, vecs[n].aok, vecs[n].dok, vecs[n].rdata);
            act_ok = {m_resp[0].addr_ok, m_resp[1].addr_ok, m_resp[0].data_ok, m_resp[1].data_ok};
            check("flags", n, 80'(act_ok), 80'(vecs[n].ok));
            check("s_req", n, 80'(s_req), 80'(exp_sreq(vecs[n].sreq, vecs[n].sel)));
            check("rdata", n, 80'({m_resp[0].rdata, m_resp[1].rdata}), 80'({vecs[n].rdata, vecs[n].rdata}));
            mon(vecs[n].rst, n);
        end

        // master 0 held off by the slave for 3 cycles, bounded wait for its addr_ok
        seen = -1;
        for (int k = 0; k < 8 && seen < 0; k++) begin
            step(0, 1, 0, (k >= 3), 0, 32'h0);
            check("hold_sreq", k, 80'(s_req), 80'(M0));
            if (m_resp[0].addr_ok) seen = k;
            mon(0, 100 + k);
        end
        check("hold_latency", 0, 80'(seen), 80'(3));
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        check("hold_data", 0, 80'({m_resp[0].data_ok, m_resp[0].rdata}), 80'({1'b1, 32'h1234_5678}));
        mon(0, 200);
        step(0, 0, 0, 0, 0, 32'h0);
        check("sb_empty", 0, 80'(sb.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
